apb_slave_regfile: RTL
======================

Name: apb_slave_regfile

Overview:
- APB slave register bank that sits directly downstream of the AHB-to-APB bridge and consumes its psel/penable/pwrite/paddr/pwdata.
- Returns prdata, pready and pslverr.
- Provides DEPTH 32-bit word registers at BASE_ADDR, with programmable wait-state insertion and address-error signalling.
- Clocked on the same hclk as the bridge.

Parameters:
- DEPTH, 16: number of 32-bit registers; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000: byte address of register 0; aligned to DEPTH*4.
- RD_WAIT, 1: wait cycles inserted on reads (0..15); effective only with APB_SLV_WAIT_EN.
- WR_WAIT, 2: wait cycles inserted on writes (0..15); effective only with APB_SLV_WAIT_EN.

Ports:
- hclk  input  1  system clock; all state changes on the rising edge.
- hreset  input  1  reset, asynchronous, active-high.
- psel  input  1  slave select from the bridge.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data, registered.
- pready  output  1  transfer completes in the current access cycle.
- pslverr  output  1  error response; valid only while pready=1.

Behaviour:
- Reset: hreset=1 asynchronously sets state=IDLE, all registers=0, prdata=0, pready=0, pslverr=0, wait counter=0.
- Decode:
  - idx = (paddr - BASE_ADDR) >> 2.
  - err = (paddr[1:0] != 0) OR (paddr < BASE_ADDR) OR (paddr >= BASE_ADDR + DEPTH*4).
- FSM states are IDLE and ACCESS.
- IDLE:
  - pready=0, pslverr=0.
  - Setup detect (psel=1, penable=0) at a clock edge: latch idx, pwrite, pwdata and err; load cnt = pwrite ? WR_WAIT : RD_WAIT; go to ACCESS.
  - On that same edge, prdata <= (read AND !err) ? reg[idx] : 0. Write setups leave prdata unchanged.
- ACCESS:
  - pready = (cnt == 0), combinational from the registered cnt.
  - pslverr = err_q AND pready.
  - While cnt != 0 and psel=1: cnt decrements each edge.
  - Completion edge (psel=1, penable=1, pready=1):
    - Write with !err_q: reg[idx_q] <= pwdata_q.
    - Error: no register changes.
    - Return to IDLE.
- Back-to-back transfers: the next transfer always starts with its own setup cycle, so minimum throughput is 1 transfer per 2 cycles with zero wait states.
- Latency: read data is valid in the first access cycle and held until the next read setup.
- Protocol violation: psel=0 while in ACCESS aborts to IDLE at the next edge, with no write and pready=0. penable=1 seen in IDLE is ignored.
- Read-after-write to the same index in consecutive transfers returns the new value, because the write commits before the next setup edge.
- Reset asserted mid-transfer aborts immediately; an in-flight write is lost.

Optional Feature:
- Macro APB_SLV_WAIT_EN.
- Defined: wait states per RD_WAIT/WR_WAIT as above.
- Undefined: cnt logic is not built and cnt is treated as 0; pready=1 in every ACCESS cycle (zero-wait slave); RD_WAIT/WR_WAIT are ignored.

Decomposition:
- Shared package apb_pkg holds:
  - state enum apb_slv_state_e {IDLE, ACCESS};
  - localparams APB_DW=32 and APB_AW=32;
  - function apb_addr_err(addr, base, depth).
- One sub-module, apb_slv_waitgen: the wait counter with load, decrement and zero flag, instantiated only under APB_SLV_WAIT_EN.

Test Plan:
- Reset value: assert hreset mid-cycle, then read addr BASE+0x0 -> prdata=0, pslverr=0, pready high after RD_WAIT access cycles.
- Write then read back: write 0xDEAD_BEEF to BASE+0x8 -> pready after 2 wait cycles; then read BASE+0x8 -> prdata=0xDEAD_BEEF after 1 wait cycle, pslverr=0.
- Address error: write 0x1234 to BASE+DEPTH*4 -> pslverr=1 with pready. Access BASE+0x2 -> pslverr=1. Register 0 still reads 0.
- Back-to-back: writes to idx 0..15 of values idx*0x11, then reads 15..0 -> every value matches; with APB_SLV_WAIT_EN undefined, each transfer takes exactly 2 cycles.
- Abort: drop psel during a write access before pready -> FSM returns to IDLE, the target register is unchanged, pready stays 0.
- Reset mid-write: assert hreset during the ACCESS wait of a write to idx 3 -> all outputs 0 immediately; idx 3 reads 0 afterwards.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types, widths and address-decode helper for the APB slave register bank.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_slv_state_e;

    // Widened to AW+1 bits so a bank ending at the top of the address map does not wrap.
    function automatic logic apb_addr_err(
        input logic [APB_AW-1:0] addr,
        input logic [APB_AW-1:0] base,
        input int unsigned       depth
    );
        logic [APB_AW:0] lim;
        lim = {1'b0, base} + ((APB_AW+1)'(depth) << 2);
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the register bank (slave).
interface apb_slave_regfile_if;
    import apb_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [APB_DW-1:0] pwdata;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_slv_waitgen.sv
// Wait-state counter: loaded at the setup edge, counts down during the access phase.
module apb_slv_waitgen (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave bank of DEPTH word registers with address-error response.
// Wait-state insertion is built only when APB_SLV_WAIT_EN is defined; otherwise zero-wait.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned       DEPTH     = 16,
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned       RD_WAIT   = 1,
    parameter int unsigned       WR_WAIT   = 2
) (
    input  logic                hclk,
    input  logic                hreset,
    apb_slave_regfile_if.slave  bus
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_slv_state_e    state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic              write_q;
    logic              err_q;
    logic [APB_DW-1:0] wdata_q;
    logic [APB_DW-1:0] prdata_q;
    logic [APB_DW-1:0] regs_q [DEPTH];

    logic [APB_AW-1:0] offset;
    logic [IDXW-1:0]   idx;
    logic              addrErr;
    logic              setup;
    logic              complete;
    logic              cntZero;
    logic              pready;
    logic              unused_offset;

    assign offset        = bus.paddr - BASE_ADDR;
    assign idx           = offset[IDXW+1:2];
    assign unused_offset = ^{offset[APB_AW-1:IDXW+2], offset[1:0]};
    assign addrErr       = apb_addr_err(bus.paddr, BASE_ADDR, DEPTH);

    assign setup    = (state_q == IDLE) && bus.psel && !bus.penable;
    assign pready   = (state_q == ACCESS) && cntZero;
    assign complete = (state_q == ACCESS) && bus.psel && bus.penable && pready;

`ifdef APB_SLV_WAIT_EN
    apb_slv_waitgen u_waitgen (
        .clk_i      (hclk),
        .rst_i      (hreset),
        .load_i     (setup),
        .load_val_i (bus.pwrite ? 4'(WR_WAIT) : 4'(RD_WAIT)),
        .dec_i      ((state_q == ACCESS) && bus.psel),
        .zero_o     (cntZero)
    );
`else
    logic unused_waits;
    assign unused_waits = ^{4'(RD_WAIT), 4'(WR_WAIT)};
    assign cntZero      = 1'b1;
`endif

    // Dropping psel mid-access is treated as an abort rather than waited out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup) state_d = ACCESS;
            end
            ACCESS: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable && pready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is fetched at the setup edge so it is already valid in the first access cycle.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                idx_q   <= idx;
                write_q <= bus.pwrite;
                err_q   <= addrErr;
                wdata_q <= bus.pwdata;
                if (!bus.pwrite) begin
                    prdata_q <= addrErr ? '0 : regs_q[idx];
                end
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (complete && write_q && !err_q) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready;
    assign bus.pslverr = err_q && pready;

endmodule
